// File: rtl/game_pkg.sv
// Screen constants, spawner state encoding and lane geometry shared by the
// enemy spawner and its neighbours.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PARK_Y   = 601;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PICK,
    ST_LAUNCH
  } spawn_state_t;

  // Pixel x of a lane, deliberately kept in 10 bits.
  function automatic logic [9:0] lane_x(input int x0, input int pitch, input logic [1:0] lane);
    logic [9:0] w_prod;
    w_prod = 10'(pitch) * 10'(lane);
    return 10'(x0) + w_prod;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free running from a nonzero seed.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_out
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= SEED;
    else        r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  assign o_out = r_lfsr;

endmodule

// File: rtl/enemy_spawner.sv
// Enemy car scheduler: waits out the spawn interval, picks the lowest parked
// slot and a lane differing from the last one, then launches it with a strobe.
module enemy_spawner
  import game_pkg::*;
#(
  parameter int N_SLOTS      = 3,
  parameter int LANE_COUNT   = 4,
  parameter int LANE_X0      = 160,
  parameter int LANE_PITCH   = 100,
  parameter int SPAWN_Y      = 0,
  parameter int PARK_Y       = game_pkg::PARK_Y,
  parameter int INTERVAL0    = 120,
  parameter int MIN_INTERVAL = 40,
  parameter int STEP         = 10,
  parameter int LEVEL_SPAWNS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_frame_tick,
  input  logic                   i_run,
  input  logic                   i_collision,
  input  logic [10*N_SLOTS-1:0]  i_pos_y_flat,
  output logic [10*N_SLOTS-1:0]  o_offset_x_flat,
  output logic [10*N_SLOTS-1:0]  o_offset_y_flat,
  output logic [N_SLOTS-1:0]     o_spawn_en,
  output logic [3:0]             o_level,
  output logic [7:0]             o_spawn_count
);

  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int TW     = 8;

  generate
    if (LANE_COUNT < 2 || LANE_COUNT > 4 ||
        LANE_X0 + (LANE_COUNT - 1) * LANE_PITCH >= SCREEN_W) begin : g_bad_lanes
      $error("enemy_spawner: lane geometry does not fit the screen");
    end
    if (PARK_Y <= SCREEN_H || PARK_Y > 1023 || INTERVAL0 > 255 ||
        MIN_INTERVAL > INTERVAL0) begin : g_bad_timing
      $error("enemy_spawner: park row or interval parameters out of range");
    end
  endgenerate

  spawn_state_t      r_state;
  logic [TW-1:0]     r_timer;
  logic [TW-1:0]     r_interval;
  logic [1:0]        r_last_lane;
  logic [1:0]        r_lane;
  logic [SLOT_W-1:0] r_slot;
  logic              r_squelch;
  logic [N_SLOTS-1:0] r_spawn_en;
  logic [3:0]        r_level;
  logic [7:0]        r_count;

  logic [15:0]       w_lfsr;
  logic              w_unused_lfsr;
  logic [N_SLOTS-1:0] w_free;
  logic              w_any_free;
  logic [SLOT_W-1:0] w_free_idx;
  logic [1:0]        w_raw;
  logic [1:0]        w_lane;
  logic [7:0]        w_count_next;
  logic              w_level_up;
  logic [TW-1:0]     w_interval_dec;
  logic              w_launch;

  lfsr16 #(.SEED(16'hACE1)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .o_out (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:2];

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      logic [9:0] r_off_x;
      logic [9:0] r_off_y;

      assign w_free[gi] = i_pos_y_flat[10*gi +: 10] >= 10'(PARK_Y);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_off_x <= 10'(LANE_X0);
          r_off_y <= 10'(PARK_Y);
        end else if (w_launch && r_slot == SLOT_W'(gi)) begin
          r_off_x <= lane_x(LANE_X0, LANE_PITCH, r_lane);
          r_off_y <= 10'(SPAWN_Y);
        end
      end

      assign o_offset_x_flat[10*gi +: 10] = r_off_x;
      assign o_offset_y_flat[10*gi +: 10] = r_off_y;
    end
  endgenerate

  always_comb begin
    w_any_free = |w_free;
    w_free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (w_free[i]) w_free_idx = SLOT_W'(i);
    end
  end

  // Bump the lane by one when the random pick repeats the previous lane.
  assign w_raw          = 2'(32'(w_lfsr[1:0]) % LANE_COUNT);
  assign w_lane         = (w_raw == r_last_lane) ? 2'((32'(w_raw) + 1) % LANE_COUNT) : w_raw;
  assign w_count_next   = r_count + 8'd1;
  assign w_level_up     = (32'(w_count_next) % LEVEL_SPAWNS) == 0;
  assign w_interval_dec = (r_interval >= TW'(MIN_INTERVAL + STEP)) ? r_interval - TW'(STEP)
                                                                    : TW'(MIN_INTERVAL);
  assign w_launch       = i_run && !i_collision && !r_squelch && (r_state == ST_LAUNCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= TW'(INTERVAL0);
      r_interval  <= TW'(INTERVAL0);
      r_last_lane <= 2'(LANE_COUNT - 1);
      r_lane      <= '0;
      r_slot      <= '0;
      r_squelch   <= 1'b0;
      r_spawn_en  <= '0;
      r_level     <= '0;
      r_count     <= '0;
    end else begin
      r_spawn_en <= '0;
      if (!i_run) begin
        r_state   <= ST_IDLE;
        r_squelch <= 1'b0;
      end else if (i_collision) begin
        // A launch caught by a collision is cancelled once play resumes.
        if (r_state == ST_LAUNCH) r_squelch <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_timer <= r_interval;
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (r_timer != '0) begin
              if (i_frame_tick) r_timer <= r_timer - TW'(1);
            end else if (w_any_free) begin
              r_state <= ST_PICK;
            end
          end
          ST_PICK: begin
            r_slot  <= w_free_idx;
            r_lane  <= w_lane;
            r_state <= ST_LAUNCH;
          end
          ST_LAUNCH: begin
            r_state   <= ST_WAIT;
            r_squelch <= 1'b0;
            if (r_squelch) begin
              r_timer <= r_interval;
            end else begin
              r_spawn_en  <= N_SLOTS'(1) << r_slot;
              r_last_lane <= r_lane;
              r_count     <= w_count_next;
              r_timer     <= w_level_up ? w_interval_dec : r_interval;
              if (w_level_up) begin
                r_interval <= w_interval_dec;
                if (r_level != 4'hF) r_level <= r_level + 4'd1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_spawn_en    = r_spawn_en & ~{N_SLOTS{i_collision}};
  assign o_level       = r_level;
  assign o_spawn_count = r_count;

endmodule

// File: tb/tb_enemy_spawner.sv
// Directed bench for enemy_spawner: spawn timing, slot priority table,
// level/interval progression, collision freeze and asynchronous reset.
module tb_enemy_spawner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        run = 1'b0;
  logic        coll = 1'b0;
  logic [29:0] pos_y = {10'd620, 10'd620, 10'd620};
  logic [29:0] off_x;
  logic [29:0] off_y;
  logic [2:0]  sen;
  logic [3:0]  level;
  logic [7:0]  cnt;

  enemy_spawner dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_frame_tick    (tick),
    .i_run           (run),
    .i_collision     (coll),
    .i_pos_y_flat    (pos_y),
    .o_offset_x_flat (off_x),
    .o_offset_y_flat (off_y),
    .o_spawn_en      (sen),
    .o_level         (level),
    .o_spawn_count   (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         p0;
    int         p1;
    int         p2;
    logic [2:0] mask;
  } vec_t;

  vec_t tbl [8];

  int n_vec = 0;
  int n_bad = 0;
  bit seen;
  int cnt_m, lvl_m, iv_m, prev_lane;
  int exp_x [3];
  int exp_y [3];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int slot_of(logic [2:0] m);
    return m[0] ? 0 : (m[1] ? 1 : 2);
  endfunction

  task automatic reset_model();
    cnt_m = 0; lvl_m = 0; iv_m = 120; prev_lane = 3;
    for (int s = 0; s < 3; s++) begin exp_x[s] = 160; exp_y[s] = 601; end
  endtask

  task automatic check_offsets(string tag);
    for (int s = 0; s < 3; s++) begin
      check({tag, "_x"}, off_x[10*s +: 10], exp_x[s]);
      check({tag, "_y"}, off_y[10*s +: 10], exp_y[s]);
    end
  endtask

  // Called while the strobe is visible: validate lane, untouched slots, counters.
  task automatic check_spawn(int slot);
    int x, lane;
    bit ok;
    x    = int'(off_x[10*slot +: 10]);
    ok   = (x >= 160) && ((x - 160) % 100 == 0) && ((x - 160) / 100 < 4);
    lane = (x - 160) / 100;
    check("lane_valid", ok, 1);
    check("lane_ne_prev", lane == prev_lane, 0);
    prev_lane = lane;
    exp_y[slot] = 0;
    for (int s = 0; s < 3; s++) begin
      check("spawn_off_y", off_y[10*s +: 10], exp_y[s]);
      if (s != slot) check("idle_slot_x", off_x[10*s +: 10], exp_x[s]);
    end
    exp_x[slot] = x;
    cnt_m = (cnt_m + 1) % 256;
    if (cnt_m % 8 == 0) begin
      if (lvl_m < 15) lvl_m++;
      iv_m = (iv_m - 10 < 40) ? 40 : iv_m - 10;
    end
    check("level", level, lvl_m);
    check("spawn_count", cnt, cnt_m);
    $display("spawn %0d: slot %0d x %0d lane %0d level %0d next_interval %0d",
             cnt_m, slot, x, lane, level, iv_m);
  endtask

  task automatic pulses(int n, int gap);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); tick = 1'b1; if (sen != 0) seen = 1;
      for (int j = 1; j < gap; j++) begin
        @(negedge clk); tick = 1'b0; if (sen != 0) seen = 1;
      end
    end
  endtask

  // iv ticks must produce exactly one strobe, on the 3rd edge after the last tick.
  task automatic spawn_once(int iv, int gap, logic [2:0] mask);
    logic [2:0] s [1:5];
    seen = 0;
    pulses(iv - 1, gap);
    repeat (6) begin @(negedge clk); if (sen != 0) seen = 1; end
    check("no_early_strobe", seen, 0);
    @(negedge clk); tick = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); tick = 1'b0; s[i] = sen;
      if (i == 4 && sen == mask) check_spawn(slot_of(mask));
    end
    check("strobe_latency", {s[1], s[2], s[3]}, 0);
    check("strobe", s[4], mask);
    check("strobe_width", s[5], 0);
  endtask

  task automatic run_pause_test();
    pulses(5, 2);
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("run0_level_kept", level, lvl_m);
    check("run0_count_kept", cnt, cnt_m);
    run = 1'b1;
    @(negedge clk);
    spawn_once(iv_m, 2, 3'b001);
  endtask

  task automatic coll_wait_test();
    seen = 0;
    pulses(10, 2);
    @(negedge clk); coll = 1'b1;
    pulses(50, 2);
    @(negedge clk); coll = 1'b0;
    check("coll_wait_quiet", seen, 0);
    spawn_once(iv_m - 10, 2, 3'b001);
  endtask

  task automatic coll_launch_test();
    seen = 0;
    pulses(iv_m - 1, 2);
    check("coll_launch_early", seen, 0);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0; if (sen != 0) seen = 1;
    @(negedge clk); if (sen != 0) seen = 1;
    @(negedge clk); if (sen != 0) seen = 1;
    coll = 1'b1;
    pulses(50, 2);
    @(negedge clk); coll = 1'b0;
    repeat (10) begin @(negedge clk); if (sen != 0) seen = 1; end
    check("coll_launch_nostrobe", seen, 0);
    check("coll_launch_count", cnt, cnt_m);
    check_offsets("coll_launch_off");
    spawn_once(iv_m, 2, 3'b001);
  endtask

  initial begin
    tbl[0] = '{100, 100, 620, 3'b100};
    tbl[1] = '{620, 620, 620, 3'b001};
    tbl[2] = '{100, 620, 620, 3'b010};
    tbl[3] = '{601, 100, 100, 3'b001};
    tbl[4] = '{600, 600, 600, 3'b000};
    tbl[5] = '{100, 1023, 100, 3'b010};
    tbl[6] = '{600, 601, 602, 3'b010};
    tbl[7] = '{1023, 1023, 1023, 3'b001};
    reset_model();

    // Reset state and first spawn with ticks every 10 clk.
    repeat (3) @(negedge clk);
    check("rst_off_x", off_x, {10'd160, 10'd160, 10'd160});
    check("rst_off_y", off_y, {10'd601, 10'd601, 10'd601});
    check("rst_spawn_en", sen, 0);
    check("rst_level", level, 0);
    check("rst_count", cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_spawn_en", sen, 0);
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    spawn_once(120, 10, 3'b001);

    // Level/interval progression to saturation, with pause and collision cases.
    while (cnt_m < 128) begin
      if (cnt_m == 9)  run_pause_test();
      if (cnt_m == 12) coll_wait_test();
      if (cnt_m == 14) coll_launch_test();
      spawn_once(iv_m, 2, 3'b001);
    end
    check("level_saturated", level, 15);

    // Asynchronous reset mid-WAIT with timer at 37.
    pulses(3, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_off_x", off_x, {10'd160, 10'd160, 10'd160});
    check("arst_off_y", off_y, {10'd601, 10'd601, 10'd601});
    check("arst_spawn_en", sen, 0);
    check("arst_level", level, 0);
    check("arst_count", cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    reset_model();
    @(negedge clk);
    check("arst_release_spawn_en", sen, 0);
    spawn_once(120, 2, 3'b001);

    // Free-slot priority table, applied after the timer has expired with all slots busy.
    @(negedge clk); rst_n = 1'b0; run = 1'b0;
    pos_y = {10'd100, 10'd100, 10'd100};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    @(negedge clk); run = 1'b1;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] s [1:4];
      @(negedge clk); tick = 1'b1; pos_y = {10'd100, 10'd100, 10'd100};
      repeat (iv_m + 3) @(negedge clk);
      tick = 1'b0;
      seen = 0;
      repeat (10) begin @(negedge clk); if (sen != 0) seen = 1; end
      check("busy_nostrobe", seen, 0);
      pos_y = {10'(tbl[v].p2), 10'(tbl[v].p1), 10'(tbl[v].p0)};
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk); s[i] = sen;
        if (i == 3 && sen != 0 && sen == tbl[v].mask) check_spawn(slot_of(tbl[v].mask));
      end
      $display("vector %0d: pos_y %0d/%0d/%0d spawn_en %b expected %b",
               v, tbl[v].p0, tbl[v].p1, tbl[v].p2, s[3], tbl[v].mask);
      check("table_latency", {s[1], s[2]}, 0);
      check("table_strobe", s[3], tbl[v].mask);
      check("table_width", s[4], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
